// File: rtl/vec_operand_loader.sv
// vec_operand_loader: fetches two 16-lane half-precision vectors (A then B)
// one lane per cycle from a 16-bit synchronous memory, packs them into two
// 256-bit operand registers, then hands them to the vector adder.
// Optional build macro: VLOADER_SPECIAL_SCREEN_EN enables the per-lane
// exponent-all-ones screen on special_mask; otherwise special_mask is 0.
module vec_operand_loader #(
    parameter int ADDR_W = 16,
    parameter int LANES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_W-1:0]     base_a,
    input  logic [ADDR_W-1:0]     base_b,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [15:0]           mem_rdata,
    output logic [16*LANES-1:0]   inval1,
    output logic [16*LANES-1:0]   inval2,
    output logic                  add_start,
    input  logic                  add_done,
    output logic                  complete,
    output logic [15:0]           special_mask
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ISSUE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base_a_q, base_b_q;
    logic [4:0]        issue_cnt;
    logic              cap_vld_p1;
    logic [4:0]        cap_idx_p1;
    logic              accept;

    assign accept = (state == IDLE) && req;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and control outputs; all outputs decode from state so an
    // asynchronous reset forces them back to idle values immediately.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        add_start  = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = FETCH;
            end
            FETCH: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = issue_cnt[4] ? base_b_q + ADDR_W'(issue_cnt[3:0])
                                         : base_a_q + ADDR_W'(issue_cnt[3:0]);
                if (issue_cnt == 5'd31) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                add_start = 1'b1;
                if (add_done) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch vector bases on acceptance and step the issue counter while fetching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_a_q  <= '0;
            base_b_q  <= '0;
            issue_cnt <= '0;
        end else if (accept) begin
            base_a_q  <= base_a;
            base_b_q  <= base_b;
            issue_cnt <= '0;
        end else if (state == FETCH) begin
            issue_cnt <= issue_cnt + 5'd1;
        end
    end

    // ---- stage boundary: read issue -> data return (one-cycle memory latency)
    // Capture tag trails the issue counter by one cycle; cleared on reset so
    // any data still in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_p1 <= 1'b0;
            cap_idx_p1 <= '0;
        end else begin
            cap_vld_p1 <= mem_rd_en;
            cap_idx_p1 <= issue_cnt;
        end
    end

    // Write the returned word into its lane; other lanes hold their value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inval1 <= '0;
            inval2 <= '0;
        end else if (cap_vld_p1) begin
            if (cap_idx_p1[4]) inval2[{cap_idx_p1[3:0], 4'b0000} +: 16] <= mem_rdata;
            else               inval1[{cap_idx_p1[3:0], 4'b0000} +: 16] <= mem_rdata;
        end
    end

`ifdef VLOADER_SPECIAL_SCREEN_EN
    // Half-precision Inf/NaN: exponent field all ones
    function automatic logic is_special(input logic [15:0] word);
        return word[14:10] == 5'h1F;
    endfunction

    // Sticky per-lane flag shared by the A and B lane with the same index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_mask <= '0;
        end else if (accept) begin
            special_mask <= '0;
        end else if (cap_vld_p1 && is_special(mem_rdata)) begin
            special_mask[cap_idx_p1[3:0]] <= 1'b1;
        end
    end
`else
    assign special_mask = '0;
`endif

endmodule
